oscillo_readout: RTL
====================

// Module: oscillo_readout
// PURPOSE
// Readout sequencer for the acquisition sample RAMs written by the trigger/acquire block. After data_ready,
// a read request makes it walk the four channel RAMs in time order, starting triggerpoint samples before the trigger address.
// It streams the selected channels' bytes on a valid/ready byte interface to the host link, then pulses done so firmware can re-arm.
// PARAMETERS
// RAM_WIDTH   10   address width of each channel RAM; depth = 2**RAM_WIDTH
// PORTS
// clk                     in   1          system clock; all logic on posedge
// rstn                    in   1          synchronous reset, active low
// data_ready              in   1          acquisition complete, RAM contents valid
// wraddress_triggerpoint  in   RAM_WIDTH  RAM write address captured at trigger
// triggerpoint            in   RAM_WIDTH  number of pre-trigger samples
// nsmp                    in   RAM_WIDTH  samples to read; 0 means 2**RAM_WIDTH
// chanmask                in   4          bit i set = emit channel i
// readreq                 in   1          start readout (level/pulse, sampled in IDLE only)
// rden                    out  1          RAM read enable
// rdaddress               out  RAM_WIDTH  RAM read address (shared by all four RAMs)
// ram_q1..ram_q4          in   8 each     RAM read data; valid exactly 1 clk after rden
// tx_data                 out  8          output byte
// tx_valid                out  1          tx_data valid
// tx_ready                in   1          sink accepts byte when tx_valid&&tx_ready
// busy                    out  1          high in any state except IDLE
// done                    out  1          one-clk pulse when the last byte has been accepted
// BEHAVIOUR
// - Reset (rstn=0 at posedge): state=IDLE; rden=0, rdaddress=0, tx_data=0, tx_valid=0, busy=0, done=0; counters cleared.
//   Reset mid-readout aborts immediately; no done pulse; partial stream is discarded by the sink.
// - States: IDLE -> ADDR -> CAPT -> SEND -> (ADDR | CSUM | FIN) -> IDLE.
// - IDLE: if readreq && data_ready: rdaddress <= wraddress_triggerpoint - triggerpoint (mod 2**RAM_WIDTH),
//   remaining <= nsmp (0 loads 2**RAM_WIDTH; counter is RAM_WIDTH+1 bits), latch chanmask, go ADDR.
//   readreq with data_ready=0 is ignored. chanmask==0 at start: go straight to FIN (or CSUM when enabled).
// - ADDR: rden=1 for one clk; go CAPT. CAPT: rden=0; latch ram_q1..4 into hold regs; point channel index at lowest set mask bit; go SEND.
// - SEND: tx_valid=1, tx_data=hold[chan]. tx_data/tx_valid held stable while tx_valid && !tx_ready.
//   On accept: advance to next set mask bit (ascending 0..3). After last selected channel: remaining-=1,
//   rdaddress+=1 (wraps 2**RAM_WIDTH-1 -> 0); remaining==0 -> CSUM/FIN, else ADDR. tx_valid drops for the ADDR/CAPT clocks.
// - Latency: readreq accepted at edge N -> first tx_valid at edge N+3; each sample costs 2 + (#selected) clks with tx_ready=1.
// - FIN: done=1 for exactly one clk, busy=0 thereafter, state=IDLE. data_ready dropping mid-readout is ignored (no abort).
// - Byte order: sample-major, channel-minor; bytes passed unmodified from RAM.
// CONFIGURATION
// - Macro OSCILLO_READOUT_CHECKSUM_EN defined: running 8-bit XOR of every emitted sample byte (cleared on start);
//   after last sample, CSUM state emits one extra byte = XOR value with the same handshake, then FIN. chanmask==0 -> sends 8'h00.
// - Macro undefined: no CSUM state, no checksum logic; stream ends after last sample byte.
// TESTING
// 1 RAM_WIDTH=10, ram[i]=i&0xFF all ch, wraddress_triggerpoint=100, triggerpoint=40, nsmp=8, chanmask=4'b0001, tx_ready=1
//   -> rdaddress 60..67, bytes 60..67 (0x3C..0x43), done one clk after 8th accept.
// 2 Wrap: wraddress_triggerpoint=5, triggerpoint=10, nsmp=12 -> addresses 1019..1023,0..6 in order.
// 3 chanmask=4'b1010, nsmp=2, ch1=0xA0+addr, ch3=0xC0+addr, start 0 -> bytes A0,C0,A1,C1; tx_ready toggling 1/0 each clk -> same bytes, tx_data stable while stalled.
// 4 readreq with data_ready=0 -> stays IDLE, busy=0, rden never high; nsmp=0 -> exactly 1024 samples then done.
// 5 rstn=0 during SEND of sample 3 -> next clk tx_valid=0, busy=0, done never pulses; new readreq restarts from computed start.
// 6 CHECKSUM_EN: bytes 0x11,0x22,0x44 -> trailing byte 0x77; chanmask=0 -> single byte 0x00 then done.

Source files
------------

// File: rtl/oscillo_readout.sv
// Readout sequencer: walks the four acquisition channel RAMs in time order and streams the selected bytes.
// Optional trailing XOR checksum byte is enabled by defining OSCILLO_READOUT_CHECKSUM_EN.
module oscillo_readout #(
    parameter int RAM_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 data_ready,
    input  logic [RAM_WIDTH-1:0] wraddress_triggerpoint,
    input  logic [RAM_WIDTH-1:0] triggerpoint,
    input  logic [RAM_WIDTH-1:0] nsmp,
    input  logic [3:0]           chanmask,
    input  logic                 readreq,
    output logic                 rden,
    output logic [RAM_WIDTH-1:0] rdaddress,
    input  logic [7:0]           ram_q1,
    input  logic [7:0]           ram_q2,
    input  logic [7:0]           ram_q3,
    input  logic [7:0]           ram_q4,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CAPT,
        S_SEND,
`ifdef OSCILLO_READOUT_CHECKSUM_EN
        S_CSUM,
`endif
        S_FIN
    } state_t;

    state_t               state, state_next;
    logic [3:0]           mask_q;
    logic [1:0]           chan;
    logic [7:0]           hold [4];
    logic [RAM_WIDTH:0]   remaining;
    logic                 start, accept, last_chan;
    logic [2:0]           first_chan, next_chan;
`ifdef OSCILLO_READOUT_CHECKSUM_EN
    logic [7:0]           csum;
`endif

    // Lowest set bit of m at index >= from; 4 means none left.
    function automatic logic [2:0] next_set(input logic [3:0] m, input logic [2:0] from);
        logic [2:0] r;
        r = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if (i >= int'(from) && m[i]) r = 3'(i);
        end
        return r;
    endfunction

    assign start      = readreq && data_ready;
    assign accept     = tx_valid && tx_ready;
    assign first_chan = next_set(mask_q, 3'd0);
    assign next_chan  = next_set(mask_q, {1'b0, chan} + 3'd1);
    assign last_chan  = next_chan[2];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: comb blocks assign a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) begin
`ifdef OSCILLO_READOUT_CHECKSUM_EN
                state_next = (chanmask == 4'd0) ? S_CSUM : S_ADDR;
`else
                state_next = (chanmask == 4'd0) ? S_FIN : S_ADDR;
`endif
            end
            S_ADDR: state_next = S_CAPT;
            S_CAPT: state_next = S_SEND;
            S_SEND: if (accept && last_chan) begin
                if (remaining == (RAM_WIDTH+1)'(1)) begin
`ifdef OSCILLO_READOUT_CHECKSUM_EN
                    state_next = S_CSUM;
`else
                    state_next = S_FIN;
`endif
                end else begin
                    state_next = S_ADDR;
                end
            end
`ifdef OSCILLO_READOUT_CHECKSUM_EN
            S_CSUM: if (accept) state_next = S_FIN;
`endif
            S_FIN:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        rden     = (state == S_ADDR);
        busy     = (state != S_IDLE);
        done     = (state == S_FIN);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state)
            S_SEND: begin
                tx_valid = 1'b1;
                tx_data  = hold[chan];
            end
`ifdef OSCILLO_READOUT_CHECKSUM_EN
            S_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum;
            end
`endif
            default: ;
        endcase
    end

    // NOTE: the four-entry hold array is plain flops, so it is reset along with the counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rdaddress <= '0;
            remaining <= '0;
            mask_q    <= '0;
            chan      <= '0;
            for (int i = 0; i < 4; i++) hold[i] <= '0;
`ifdef OSCILLO_READOUT_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    rdaddress <= wraddress_triggerpoint - triggerpoint;
                    remaining <= (nsmp == '0) ? {1'b1, {RAM_WIDTH{1'b0}}} : {1'b0, nsmp};
                    mask_q    <= chanmask;
`ifdef OSCILLO_READOUT_CHECKSUM_EN
                    csum      <= '0;
`endif
                end
                S_CAPT: begin
                    hold[0] <= ram_q1;
                    hold[1] <= ram_q2;
                    hold[2] <= ram_q3;
                    hold[3] <= ram_q4;
                    chan    <= first_chan[1:0];
                end
                S_SEND: if (accept) begin
`ifdef OSCILLO_READOUT_CHECKSUM_EN
                    csum <= csum ^ tx_data;
`endif
                    if (last_chan) begin
                        remaining <= remaining - (RAM_WIDTH+1)'(1);
                        rdaddress <= rdaddress + RAM_WIDTH'(1);
                    end else begin
                        chan <= next_chan[1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
